seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, handshaked successor to the core combinational ALU.
- Registers operands and opcode on a valid/ready input channel and computes logic/add/sub ops in one cycle.
- Runs multiply (and optionally divide) as a WIDTH-cycle iterative engine.
- Returns result plus NZCV flags on a valid/ready output channel; sits between decode/issue and writeback in the execute stage.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- OPW, 4, opcode width in bits.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/opcode valid
- in_ready  output  1  block can accept an operation
- in_op  input  OPW  opcode
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_res  output  WIDTH  result
- out_flags  output  4  {N,Z,C,V}
- out_err  output  1  illegal opcode

Behaviour:
- Opcodes: 0 THA(a), 1 THB(b), 2 ADD, 3 SUB, 4 MUL, 5 AND, 6 ORR, 7 XOR; 8 DIV, 9 MOD only with the optional feature; all others illegal.
- Reset (async, rst_n=0):
  - state=IDLE.
  - out_valid=0, out_res=0, out_flags=0, out_err=0.
  - Internal counters cleared.
- Accept: transfer when in_valid && in_ready at a rising edge.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back single-cycle ops at one per clock.
- State IDLE:
  - On accept, a single-cycle or illegal op goes to DONE.
  - On accept, MUL/DIV/MOD goes to BUSY with cnt=0.
- State BUSY:
  - One iteration per clock.
  - After WIDTH iterations (cnt==WIDTH-1), go to DONE.
  - in_ready=0; new in_valid is ignored.
- State DONE:
  - out_valid=1; outputs held stable until out_ready.
  - On out_ready with no new accept, go to IDLE.
  - On out_ready with a simultaneous accept, behave as IDLE accept; the new result replaces the old next cycle.
- Latency, accept edge to out_valid:
  - 1 cycle for single-cycle ops.
  - WIDTH+1 cycles for MUL/DIV/MOD.
- Arithmetic: all results truncated to WIDTH bits.
- MUL:
  - Unsigned shift-add.
  - out_res = low WIDTH bits of the product.
  - C=1 iff the upper WIDTH product bits are nonzero.
  - V=0.
- Flags:
  - N=out_res[WIDTH-1]; Z=(out_res==0).
  - ADD: C=carry out; V=signed overflow (operands of equal sign, result sign differs).
  - SUB: C=1 iff a>=b unsigned (no borrow); V=signed overflow (operand signs differ, result sign != a sign).
  - Logic/THA/THB: C=0, V=0.
- Illegal opcode: out_res=0, flags={0,1,0,0}, out_err=1, latency 1; out_err=0 for legal ops.
- No X is ever driven on outputs.
- Mid-operation reset: aborts any BUSY/DONE op immediately; nothing is emitted after release.
- Output valid must not drop without out_ready (standard valid/ready rule); the bench checks stability of out_res/flags while out_valid && !out_ready.

Optional Feature:
- Macro: SEQ_ALU_DIV_EN.
- With it defined:
  - Opcodes 8 DIV (a/b unsigned quotient) and 9 MOD (remainder) are legal.
  - Both use a restoring divider sharing the BUSY iteration counter, latency WIDTH+1.
  - Divide by zero: quotient all-ones, remainder=a, V=1, C=0, out_err=0.
  - Normal division: C=0, V=0.
- Without it: opcodes 8 and 9 are illegal (out_res=0, out_err=1, latency 1); no divider logic is synthesised.

Test Plan:
- WIDTH=32, ADD a=32'hFFFF_FFFF b=1, out_ready=1 -> next cycle out_valid=1, res=0, flags N=0 Z=1 C=1 V=0.
- SUB a=32'h8000_0000 b=1 -> res=32'h7FFF_FFFF, N=0 Z=0 C=1 V=1.
- Back-to-back: ops AND, ORR, XOR on consecutive cycles with out_ready=1 -> three results on three consecutive cycles, in_ready held 1.
- MUL a=32'h0001_0000 b=32'h0001_0000 -> in_ready=0 for 32 cycles, out_valid at cycle 33, res=0, C=1.
- Backpressure plus reset:
  - THA a=5 with out_ready=0 for 4 cycles -> res=5 held stable, in_ready=0.
  - Then rst_n=0 mid-MUL -> out_valid=0 immediately, in_ready=1 after release.
- Opcode 8 a=100 b=7 -> with SEQ_ALU_DIV_EN: res=14 after 33 cycles; opcode 9 gives 2; b=0 gives res=32'hFFFF_FFFF, V=1. Without the macro: res=0, out_err=1 after 1 cycle.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with iterative multiply (optional divide via SEQ_ALU_DIV_EN)
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int OPW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [3:0]       out_flags,
  output logic             out_err
);
  localparam logic [OPW-1:0] OP_THA = OPW'(0);
  localparam logic [OPW-1:0] OP_THB = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB = OPW'(3);
  localparam logic [OPW-1:0] OP_MUL = OPW'(4);
  localparam logic [OPW-1:0] OP_AND = OPW'(5);
  localparam logic [OPW-1:0] OP_ORR = OPW'(6);
  localparam logic [OPW-1:0] OP_XOR = OPW'(7);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] it_n;
  logic [2*WIDTH-1:0] mul_n;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH:0]     add_s;
  logic [WIDTH:0]     sub_s;
  logic [WIDTH-1:0]   s_res;
  logic [WIDTH-1:0]   f_res;
  logic               s_c, s_v, f_c, f_v;
  logic               accept, multi, legal;
  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign add_s    = {1'b0, in_a} + {1'b0, in_b};
  assign sub_s    = {1'b0, in_a} - {1'b0, in_b};
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
  assign mul_n    = {mul_sum, acc[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
  localparam logic [OPW-1:0] OP_DIV = OPW'(8);
  localparam logic [OPW-1:0] OP_MOD = OPW'(9);
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] dif;
  logic             ge;
  assign multi = (in_op == OP_MUL) || (in_op == OP_DIV) || (in_op == OP_MOD);
  assign legal = in_op <= OP_MOD;
  assign trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign dif   = trial[WIDTH-1:0] - b_q;
  assign ge    = trial >= {1'b0, b_q};
  assign it_n  = (op_q == OP_MUL) ? mul_n : {(ge ? dif : trial[WIDTH-1:0]), acc[WIDTH-2:0], ge};
  // final result of the iterative engine: product, quotient or remainder
  always_comb begin
    f_res = (op_q == OP_MOD) ? it_n[2*WIDTH-1:WIDTH] : it_n[WIDTH-1:0];
    f_c   = (op_q == OP_MUL) ? |it_n[2*WIDTH-1:WIDTH] : 1'b0;
    f_v   = (op_q != OP_MUL) && (b_q == '0);
  end
`else
  assign multi = in_op == OP_MUL;
  assign legal = in_op <= OP_XOR;
  assign it_n  = mul_n;
  // final result of the multiplier: low half, carry flags a nonzero high half
  always_comb begin
    f_res = it_n[WIDTH-1:0];
    f_c   = |it_n[2*WIDTH-1:WIDTH];
    f_v   = 1'b0;
  end
`endif
  // single-cycle result and carry/overflow; illegal ops fall through to zero
  always_comb begin
    s_res = (in_op == OP_THA) ? in_a :
            (in_op == OP_THB) ? in_b :
            (in_op == OP_ADD) ? add_s[WIDTH-1:0] :
            (in_op == OP_SUB) ? sub_s[WIDTH-1:0] :
            (in_op == OP_AND) ? (in_a & in_b) :
            (in_op == OP_ORR) ? (in_a | in_b) :
            (in_op == OP_XOR) ? (in_a ^ in_b) : '0;
    s_c   = (in_op == OP_ADD) ? add_s[WIDTH] :
            (in_op == OP_SUB) ? ~sub_s[WIDTH] : 1'b0;
    s_v   = (in_op == OP_ADD) ? ((in_a[WIDTH-1] == in_b[WIDTH-1]) && (add_s[WIDTH-1] != in_a[WIDTH-1])) :
            (in_op == OP_SUB) ? ((in_a[WIDTH-1] != in_b[WIDTH-1]) && (sub_s[WIDTH-1] != in_a[WIDTH-1])) : 1'b0;
  end
  // control FSM, iteration engine and registered output channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      a_q       <= '0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_flags <= '0;
      out_err   <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      op_q      <= '0;
      b_q       <= '0;
`endif
    end else if (accept) begin
      a_q       <= in_a;
      cnt       <= '0;
      acc       <= {{WIDTH{1'b0}}, ((in_op == OP_MUL) ? in_b : in_a)};
`ifdef SEQ_ALU_DIV_EN
      op_q      <= in_op;
      b_q       <= in_b;
`endif
      state     <= multi ? BUSY : DONE;
      out_valid <= !multi;
      out_res   <= s_res;
      out_flags <= {s_res[WIDTH-1], s_res == '0, s_c, s_v};
      out_err   <= !legal;
    end else if (state == BUSY) begin
      acc <= it_n;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        state     <= DONE;
        out_valid <= 1'b1;
        out_res   <= f_res;
        out_flags <= {f_res[WIDTH-1], f_res == '0, f_c, f_v};
        out_err   <= 1'b0;
      end
    end else if (state == DONE && out_ready) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vector table plus handshake/reset sequences for seq_alu
module tb_seq_alu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_res;
  logic [3:0]  out_flags;
  logic        out_err;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flags;
    logic        err;
    int          lat;
  } vec_t;
  vec_t vt[20];
  seq_alu #(.WIDTH(32), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_res(out_res), .out_flags(out_flags), .out_err(out_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic run_vec(input int i);
    int  lat;
    bit  busy_ok;
    @(negedge clk);
    in_op = vt[i].op; in_a = vt[i].a; in_b = vt[i].b; in_valid = 1'b1;
    chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    lat = 1;
    busy_ok = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) break;
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk);
      lat++;
    end
    chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].lat));
    chk($sformatf("v%0d_busy_ready_low", i), {31'd0, busy_ok}, 32'd1);
    chk($sformatf("v%0d_res", i), out_res, vt[i].res);
    chk($sformatf("v%0d_flags", i), {28'd0, out_flags}, {28'd0, vt[i].flags});
    chk($sformatf("v%0d_err", i), {31'd0, out_err}, {31'd0, vt[i].err});
  endtask
  initial begin
    int seen;
    vt[0]  = '{4'd0, 32'd5,          32'd9,          32'd5,          4'b0000, 1'b0, 1};
    vt[1]  = '{4'd1, 32'd5,          32'h8000_0000,  32'h8000_0000,  4'b1000, 1'b0, 1};
    vt[2]  = '{4'd2, 32'hFFFF_FFFF,  32'd1,          32'd0,          4'b0110, 1'b0, 1};
    vt[3]  = '{4'd3, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  4'b0011, 1'b0, 1};
    vt[4]  = '{4'd2, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  4'b1001, 1'b0, 1};
    vt[5]  = '{4'd2, 32'h8000_0000,  32'h8000_0000,  32'd0,          4'b0111, 1'b0, 1};
    vt[6]  = '{4'd3, 32'd1,          32'd2,          32'hFFFF_FFFF,  4'b1000, 1'b0, 1};
    vt[7]  = '{4'd3, 32'd5,          32'd5,          32'd0,          4'b0110, 1'b0, 1};
    vt[8]  = '{4'd5, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0,  4'b0000, 1'b0, 1};
    vt[9]  = '{4'd6, 32'hF000_0000,  32'h0000_000F,  32'hF000_000F,  4'b1000, 1'b0, 1};
    vt[10] = '{4'd7, 32'hAAAA_AAAA,  32'hAAAA_AAAA,  32'd0,          4'b0100, 1'b0, 1};
    vt[11] = '{4'd10, 32'd3,         32'd4,          32'd0,          4'b0100, 1'b1, 1};
    vt[12] = '{4'd15, 32'd3,         32'd4,          32'd0,          4'b0100, 1'b1, 1};
    vt[13] = '{4'd4, 32'h0001_0000,  32'h0001_0000,  32'd0,          4'b0110, 1'b0, 33};
    vt[14] = '{4'd4, 32'd7,          32'd6,          32'd42,         4'b0000, 1'b0, 33};
    vt[15] = '{4'd4, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  4'b1010, 1'b0, 33};
`ifdef SEQ_ALU_DIV_EN
    vt[16] = '{4'd8, 32'd100,        32'd7,          32'd14,         4'b0000, 1'b0, 33};
    vt[17] = '{4'd9, 32'd100,        32'd7,          32'd2,          4'b0000, 1'b0, 33};
    vt[18] = '{4'd8, 32'd100,        32'd0,          32'hFFFF_FFFF,  4'b1001, 1'b0, 33};
    vt[19] = '{4'd9, 32'd100,        32'd0,          32'd100,        4'b0001, 1'b0, 33};
`else
    vt[16] = '{4'd8, 32'd100,        32'd7,          32'd0,          4'b0100, 1'b1, 1};
    vt[17] = '{4'd9, 32'd100,        32'd7,          32'd0,          4'b0100, 1'b1, 1};
    vt[18] = '{4'd8, 32'd100,        32'd0,          32'd0,          4'b0100, 1'b1, 1};
    vt[19] = '{4'd9, 32'd100,        32'd0,          32'd0,          4'b0100, 1'b1, 1};
`endif
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_res", out_res, 32'd0);
    chk("rst_out_flags", {28'd0, out_flags}, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) run_vec(i);
    @(negedge clk);
    in_op = 4'd5; in_a = 32'hFF00_FF00; in_b = 32'h0FF0_0FF0; in_valid = 1'b1;
    @(negedge clk);
    chk("b2b_and_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_and_res", out_res, 32'h0F00_0F00);
    chk("b2b_ready1", {31'd0, in_ready}, 32'd1);
    in_op = 4'd6;
    @(negedge clk);
    chk("b2b_orr_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_orr_res", out_res, 32'hFFF0_FFF0);
    chk("b2b_ready2", {31'd0, in_ready}, 32'd1);
    in_op = 4'd7;
    @(negedge clk);
    chk("b2b_xor_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_xor_res", out_res, 32'hF0F0_F0F0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_drain", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
    in_op = 4'd0; in_a = 32'd5; in_b = 32'd77; in_valid = 1'b1;
    @(negedge clk);
    in_op = 4'd1; in_a = 32'd9;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp%0d_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp%0d_res", k), out_res, 32'd5);
      chk($sformatf("bp%0d_flags", k), {28'd0, out_flags}, 32'd0);
      chk($sformatf("bp%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {31'd0, out_valid}, 32'd0);
    in_op = 4'd4; in_a = 32'd3; in_b = 32'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_res", out_res, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("post_rst_silent", 32'(seen), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
